dmem_lsu: RTL and testbench
===========================

// Module: dmem_lsu
// PURPOSE
//  Parametrised data memory with load/store unit for the single-cycle/multi-cycle RV32I core.
//  - Adds sub-word access (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte-lane writes and load extension.
//  - Adds alignment and range fault detection.
//  - Adds a valid/ready request/response handshake with configurable read latency.
//  Sits between the core's EX/MEM stage and the word-addressed RAM array.
// PARAMETERS
//  DEPTH    256  number of 32-bit words; power of two, >= 4
//  LATENCY  1    cycles from request accept to rsp_valid; legal 1..15
//  IDX_W    $clog2(DEPTH)  localparam: word index width
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  rst         in   1   synchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   block can accept a request (high only in IDLE)
//  req_we      in   1   1 = store, 0 = load
//  req_funct3  in   3   RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data; B uses [7:0], H uses [15:0]
//  rsp_valid   out  1   response present; held until rsp_ready
//  rsp_ready   in   1   consumer accepts response
//  rsp_rdata   out  32  extended load data; 0 for stores and faults
//  rsp_fault   out  1   request was misaligned, out of range, or had illegal funct3
// BEHAVIOUR
//  - Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0, FSM=IDLE, counter=0.
//  - rst does not clear RAM. RAM is zero-initialised at time 0 only.
//  - FSM states and transitions:
//    - IDLE: req_ready=1. On req_valid, accept the request: go to WAIT, load counter with LATENCY-1.
//    - WAIT: counter decrements each cycle. At 0, go to RESP and drive rsp_*.
//    - RESP: hold rsp_* stable. When rsp_ready=1, go to IDLE (rsp_valid=0 next cycle).
//  - Latency: rsp_valid rises exactly LATENCY cycles after the accept edge.
//    No new request is accepted before the response handshake completes.
//  - Fault checks (evaluated at accept):
//    - H/HU misaligned when addr[0]=1.
//    - W misaligned when addr[1:0]!=0.
//    - Out of range when addr[31:2] >= DEPTH.
//    - Illegal funct3: 011, 110, 111 for loads; anything other than 000/001/010 for stores.
//  - On fault: no RAM write, rsp_fault=1, rsp_rdata=0.
//  - Store: commits on the accept edge with byte-enables.
//    - SB: lane addr[1:0] <= wdata[7:0].
//    - SH: lanes {addr[1],0} and {addr[1],1} <= wdata[15:0].
//    - SW: all four lanes.
//    - Unselected bytes are unchanged.
//  - Load: the word at addr[IDX_W+1:2] is read on the accept edge (pre-write value irrelevant: loads never write).
//    - The lane is selected by addr[1:0].
//    - B/H are sign-extended; BU/HU are zero-extended; W is passed through.
//    - Result is held in an output register until the response handshake completes.
//  - Request fields are sampled only at accept; changes while busy are ignored.
//  - rst in WAIT or RESP aborts the transaction and drops the response.
//    A store already committed at accept stays committed.
//  - rst and req_valid in the same cycle: rst wins, no accept.
// STRUCTURE
//  - dmem_pkg holds:
//    - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
//    - FSM state encoding ST_IDLE/ST_WAIT/ST_RESP.
//    - Latency counter width constant LAT_W=4.
//  - Sub-module dmem_lane_unit (combinational): from funct3, addr[1:0] and wdata, produce
//    4-bit byte-enable, lane-shifted write data, and misalign flag; also extracts and extends load data.
//  - Top level holds the RAM array, FSM, counter, and response registers.
// TESTING
//  - SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata=0xDEADBEEF, fault=0, rsp_valid exactly LATENCY cycles after accept.
//  - SB 0x80 @0x11, then LB @0x11 -> 0xFFFFFF80; LBU @0x11 -> 0x00000080; LW @0x10 -> 0xDEAD80EF.
//  - SH 0x1234 @0x12, then LH @0x12 -> 0x00001234; LW @0x10 -> 0x123480EF.
//  - LW @0x13, LH @0x01, LW @(DEPTH*4) -> rsp_fault=1, rsp_rdata=0; RAM word 4 unchanged after SW @0x13.
//  - rsp_ready held low 5 cycles -> rsp_* stable, req_ready=0; req_valid pulses in that window are not accepted.
//  - rst asserted in WAIT with LATENCY=4 -> rsp_valid never rises, req_ready=1 next cycle; the earlier committed store is still readable.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared constants and types for the data-memory load/store unit.
// Holds the funct3 encodings, FSM states and latency counter width.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int unsigned LAT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Stores have no unsigned variants, so BU/HU are illegal for them.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      if (we)
         return !(f3 inside {F3_B, F3_H, F3_W});
      else
         return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bus between the core's memory stage and dmem_lsu.
// Request and response each use a valid/ready handshake.
interface dmem_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault
   );
endinterface

// File: rtl/dmem_lane_unit.sv
// Combinational byte-lane logic: store byte-enables and shifted data,
// misalignment detection, and load lane extraction with extension.
module dmem_lane_unit
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata_ext,
   output logic        misalign
);

   logic [7:0]  sel_b;
   logic [15:0] sel_h;

   assign sel_b = rword[{lane, 3'b000} +: 8];
   assign sel_h = lane[1] ? rword[31:16] : rword[15:0];

   always_comb begin
      be        = '0;
      wdata_sh  = '0;
      rdata_ext = '0;
      misalign  = 1'b0;
      case (funct3)
         F3_B, F3_BU: begin
            be        = 4'b0001 << lane;
            wdata_sh  = {4{wdata[7:0]}};
            rdata_ext = (funct3 == F3_B) ? {{24{sel_b[7]}}, sel_b} : {24'd0, sel_b};
         end
         F3_H, F3_HU: begin
            be        = lane[1] ? 4'b1100 : 4'b0011;
            wdata_sh  = {2{wdata[15:0]}};
            rdata_ext = (funct3 == F3_H) ? {{16{sel_h[15]}}, sel_h} : {16'd0, sel_h};
            misalign  = lane[0];
         end
         F3_W: begin
            be        = 4'b1111;
            wdata_sh  = wdata;
            rdata_ext = rword;
            misalign  = (lane != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Word-addressed data RAM with RV32I load/store unit, fault detection
// and a fixed-latency valid/ready response path.
module dmem_lsu
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 1
) (
   input  logic       clk,
   input  logic       rst,
   dmem_lsu_if.slave  bus
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   // Zeroed at time 0 only; reset leaves contents intact.
   logic [31:0] mem [DEPTH] = '{default: '0};

   state_t             state, state_nx;
   logic [LAT_W-1:0]   cnt, cnt_nx;
   logic [31:0]        rdata_q;
   logic               fault_q;

   logic [IDX_W-1:0]   idx;
   logic               in_range;
   logic               fault;
   logic               accept;
   logic [3:0]         be;
   logic [31:0]        wdata_sh;
   logic [31:0]        rdata_ext;
   logic               misalign;

   assign idx      = bus.req_addr[IDX_W+1:2];
   assign in_range = (bus.req_addr[31:2] < 30'(DEPTH));
   assign fault    = misalign || !in_range || f3_illegal(bus.req_we, bus.req_funct3);
   assign accept   = (state == ST_IDLE) && bus.req_valid && !rst;

   dmem_lane_unit u_lane (
      .funct3    (bus.req_funct3),
      .lane      (bus.req_addr[1:0]),
      .wdata     (bus.req_wdata),
      .rword     (mem[idx]),
      .be        (be),
      .wdata_sh  (wdata_sh),
      .rdata_ext (rdata_ext),
      .misalign  (misalign)
   );

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         ST_IDLE: if (bus.req_valid) begin
            state_nx = ST_WAIT;
            cnt_nx   = LAT_W'(LATENCY - 1);
         end
         ST_WAIT: begin
            if (cnt == '0) state_nx = ST_RESP;
            else           cnt_nx   = cnt - LAT_W'(1);
         end
         ST_RESP: if (bus.rsp_ready) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else if (accept) begin
         fault_q <= fault;
         rdata_q <= (fault || bus.req_we) ? '0 : rdata_ext;
      end
   end

   always_ff @(posedge clk) begin
      if (accept && bus.req_we && !fault) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
         end
      end
   end

   assign bus.req_ready = (state == ST_IDLE);
   assign bus.rsp_valid = (state == ST_RESP);
   assign bus.rsp_rdata = bus.rsp_valid ? rdata_q : '0;
   assign bus.rsp_fault = bus.rsp_valid && fault_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: a driver queues expected responses at
// accept, a monitor compares data, fault and latency when rsp_valid is seen.
module tb_dmem_lsu;
   import dmem_pkg::*;

   localparam int unsigned DEPTH = 256;
   localparam int          LAT   = 4;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   exp_t q[$];

   dmem_lsu_if bus();

   dmem_lsu #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!bus.req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) check("idle_timeout", 32'(bus.req_ready), 32'd1);
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_f, input logic push);
      @(negedge clk);
      wait_idle();
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      @(posedge clk);
      #1;
      if (push) q.push_back('{rdata: exp_rd, fault: exp_f, acc: cyc});
      @(negedge clk);
      bus.req_valid  = 1'b0;
      bus.req_addr   = 32'hFFFF_FFFF;
      bus.req_wdata  = 32'h0;
   endtask

   // Monitor samples just after the falling edge, after the driver settles inputs.
   initial begin
      int  first;
      logic prev;
      first = 0;
      prev  = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            prev = 1'b0;
         end else if (bus.rsp_valid) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 with rdata %h, want no response", bus.rsp_rdata);
            end else begin
               if (!prev) begin
                  first = cyc;
                  check("latency", 32'(first - q[0].acc), 32'(LAT));
               end
               check("rsp_rdata", bus.rsp_rdata, q[0].rdata);
               check("rsp_fault", 32'(bus.rsp_fault), 32'(q[0].fault));
               check("req_ready_busy", 32'(bus.req_ready), 32'd0);
               if (bus.rsp_ready) begin
                  void'(q.pop_front());
                  prev = 1'b0;
               end else begin
                  prev = 1'b1;
               end
            end
         end else begin
            prev = 1'b0;
         end
      end
   end

   initial begin
      int   n;
      logic stayed_low;
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.rsp_ready  = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_req_ready", 32'(bus.req_ready), 32'd1);
      check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
      check("reset_rsp_fault", 32'(bus.rsp_fault), 32'd0);
      rst = 1'b0;

      issue(1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        0, 1);
      issue(0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 0, 1);
      issue(1, F3_B,  32'h11, 32'h00000080, 32'h0,        0, 1);
      issue(0, F3_B,  32'h11, 32'h0,        32'hFFFFFF80, 0, 1);
      issue(0, F3_BU, 32'h11, 32'h0,        32'h00000080, 0, 1);
      issue(0, F3_W,  32'h10, 32'h0,        32'hDEAD80EF, 0, 1);
      issue(1, F3_H,  32'h12, 32'h00001234, 32'h0,        0, 1);
      issue(0, F3_H,  32'h12, 32'h0,        32'h00001234, 0, 1);
      issue(0, F3_W,  32'h10, 32'h0,        32'h123480EF, 0, 1);

      // Faults: misaligned, out of range, illegal funct3.
      issue(0, F3_W,   32'h13,  32'h0,        32'h0, 1, 1);
      issue(0, F3_H,   32'h01,  32'h0,        32'h0, 1, 1);
      issue(0, F3_W,   32'h400, 32'h0,        32'h0, 1, 1);
      issue(1, F3_W,   32'h13,  32'hFFFFFFFF, 32'h0, 1, 1);
      issue(1, F3_BU,  32'h10,  32'hFFFFFFFF, 32'h0, 1, 1);
      issue(0, 3'b011, 32'h10,  32'h0,        32'h0, 1, 1);
      issue(0, 3'b110, 32'h10,  32'h0,        32'h0, 1, 1);
      issue(0, F3_W,   32'h10,  32'h0,        32'h123480EF, 0, 1);
      issue(1, F3_W,   32'h400, 32'h55555555, 32'h0, 1, 1);
      issue(0, F3_W,   32'h00,  32'h0,        32'h0, 0, 1);

      issue(1, F3_H,  32'h02, 32'h00008001, 32'h0,        0, 1);
      issue(0, F3_H,  32'h02, 32'h0,        32'hFFFF8001, 0, 1);
      issue(0, F3_HU, 32'h02, 32'h0,        32'h00008001, 0, 1);
      issue(0, F3_W,  32'h00, 32'h0,        32'h80010000, 0, 1);

      // Backpressure: response held while stray requests are offered.
      wait_idle();
      bus.rsp_ready = 1'b0;
      issue(0, F3_W, 32'h10, 32'h0, 32'h123480EF, 0, 1);
      n = 0;
      while (!bus.rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("stall_rsp_seen", 32'(bus.rsp_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         check("stall_req_ready", 32'(bus.req_ready), 32'd0);
         bus.req_valid  = 1'b1;
         bus.req_we     = 1'b1;
         bus.req_funct3 = F3_W;
         bus.req_addr   = 32'h10;
         bus.req_wdata  = 32'h0;
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      issue(0, F3_W, 32'h10, 32'h0, 32'h123480EF, 0, 1);

      // Reset during WAIT drops the response but keeps the committed store.
      wait_idle();
      issue(1, F3_W, 32'h20, 32'hCAFEF00D, 32'h0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_abort_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      stayed_low = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (bus.rsp_valid) stayed_low = 1'b0;
      end
      check("rst_abort_no_rsp", 32'(stayed_low), 32'd1);
      issue(0, F3_W, 32'h20, 32'h0, 32'hCAFEF00D, 0, 1);

      wait_idle();
      repeat (2) @(negedge clk);
      check("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
